des_sbox_engine: RTL and testbench

DES_SBOX_ENGINE -- requirements
Module: des_sbox_engine

---
 rtl/des_pkg.sv | 36 +++
 rtl/des_sbox_lut.sv | 12 +
 rtl/des_sbox_engine.sv | 108 ++++++++++
 tb/tb_des_sbox_engine.sv | 228 ++++++++++++++++++++++
 4 files changed

// File: rtl/des_pkg.sv
// Shared constants, FSM state type and the eight DES S-box tables.
// Each table is one 256-bit constant: entry 0 is the top nibble, indexed by {row, col}.
package des_pkg;

  localparam int IN_W      = 48;
  localparam int OUT_W     = 32;
  localparam int FIELD_W   = 6;
  localparam int NIBBLE_W  = 4;
  localparam int NUM_BOXES = 8;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_RUN  = 2'd1,
    ST_DONE = 2'd2
  } state_e;

  localparam logic [255:0] SBOX [NUM_BOXES] = '{
    256'hE4D12FB83A6C5907_0F74E2D1A6CB9538_41E8D62BFC973A50_FC8249175B3EA06D,
    256'hF18E6B34972DC05A_3D47F28EC01A69B5_0E7BA4D158C6932F_D8A13F42B67C05E9,
    256'hA09E63F51DC7B428_D70934A6285ECBF1_D6498F30B12C5AE7_1AD069874FE3B52C,
    256'h7DE3069A1285BC4F_D8B56F03472C1AE9_A690CB7DF13E5284_3F06A1D8945BC72E,
    256'h2C417AB6853FD0E9_EB2C47D150FA3986_421BAD78F9C5630E_B8C71E2D6F09A453,
    256'hC1AF92680D34E75B_AF427C9561DE0B38_9EF528C3704A1DB6_432C95FABE17608D,
    256'h4B2EF08D3C975A61_D0B7491AE35C2F86_14BDC37EAF680592_6BD814A7950FE23C,
    256'hD2846FB1A93E50C7_1FD8A374C56B0E92_7B419CE206ADF358_21E74A8DFC90356B
  };

  // Row comes from the outer bits {b5,b0}, column from the inner bits b4..b1.
  function automatic logic [NIBBLE_W-1:0] sbox_lookup(input logic [2:0] box,
                                                      input logic [FIELD_W-1:0] field);
    logic [5:0] idx;
    idx = {field[5], field[0], field[4:1]};
    return SBOX[box][255 - 4*idx -: NIBBLE_W];
  endfunction

endpackage

// File: rtl/des_sbox_lut.sv
// One combinational S-box lookup: selected box plus its 6-bit field gives a nibble.
module des_sbox_lut
  import des_pkg::*;
(
  input  logic [2:0]          box_idx,
  input  logic [FIELD_W-1:0]  field,
  output logic [NIBBLE_W-1:0] nibble
);

  always_comb nibble = sbox_lookup(box_idx, field);

endmodule

// File: rtl/des_sbox_engine.sv
// Iterative DES S-box substitution: LANES boxes per cycle over 8/LANES RUN steps,
// with valid/ready handshakes on both sides and back-to-back restart from DONE.
module des_sbox_engine
  import des_pkg::*;
#(
  parameter int LANES = 2
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [IN_W-1:0]  in_data,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [OUT_W-1:0] out_data,
  output logic             busy
);

  localparam int STEPS  = NUM_BOXES / LANES;
  localparam int STEP_W = (STEPS > 1) ? $clog2(STEPS) : 1;
  localparam logic [STEP_W-1:0] LAST_STEP = STEP_W'(STEPS - 1);

  if (!(LANES == 1 || LANES == 2 || LANES == 4 || LANES == 8)) begin : g_lanes_check
    $error("des_sbox_engine: LANES must be 1, 2, 4 or 8");
  end

  state_e            state_q, state_d;
  logic [STEP_W-1:0] step_q, step_d;
  logic [IN_W-1:0]   data_q, data_d;
  logic [OUT_W-1:0]  result_q, result_d;
  logic              out_valid_q, out_valid_d;
  logic              busy_q, busy_d;

  logic [2:0]          box_idx [LANES];
  logic [FIELD_W-1:0]  field   [LANES];
  logic [NIBBLE_W-1:0] nib     [LANES];

  for (genvar j = 0; j < LANES; j++) begin : g_lane
    assign box_idx[j] = 3'(int'(step_q) * LANES + j);
    assign field[j]   = data_q[IN_W-1 - FIELD_W*box_idx[j] -: FIELD_W];
    des_sbox_lut u_lut (
      .box_idx (box_idx[j]),
      .field   (field[j]),
      .nibble  (nib[j])
    );
  end

  assign in_ready  = (state_q == ST_IDLE) || ((state_q == ST_DONE) && out_ready);
  assign out_valid = out_valid_q;
  assign out_data  = result_q;
  assign busy      = busy_q;

  always_comb begin
    state_d  = state_q;
    step_d   = step_q;
    data_d   = data_q;
    result_d = result_q;
    case (state_q)
      ST_IDLE: begin
        if (in_valid) begin
          data_d  = in_data;
          step_d  = '0;
          state_d = ST_RUN;
        end
      end
      ST_RUN: begin
        for (int j = 0; j < LANES; j++) begin
          result_d[OUT_W-1 - NIBBLE_W*box_idx[j] -: NIBBLE_W] = nib[j];
        end
        if (step_q == LAST_STEP) state_d = ST_DONE;
        else                     step_d  = step_q + 1'b1;
      end
      ST_DONE: begin
        if (out_ready) begin
          if (in_valid) begin
            data_d  = in_data;
            step_d  = '0;
            state_d = ST_RUN;
          end else begin
            state_d = ST_IDLE;
          end
        end
      end
      default: state_d = ST_IDLE;
    endcase
    out_valid_d = (state_d == ST_DONE);
    busy_d      = (state_d != ST_IDLE);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= ST_IDLE;
      step_q      <= '0;
      data_q      <= '0;
      result_q    <= '0;
      out_valid_q <= 1'b0;
      busy_q      <= 1'b0;
    end else begin
      state_q     <= state_d;
      step_q      <= step_d;
      data_q      <= data_d;
      result_q    <= result_d;
      out_valid_q <= out_valid_d;
      busy_q      <= busy_d;
    end
  end

endmodule

// File: tb/tb_des_sbox_engine.sv
// Bench for des_sbox_engine: one instance per legal LANES value, known-answer table,
// handshake corner sequences and a random sweep against a table model.
module tb_des_sbox_engine;
  import des_pkg::*;

  logic        clk = 1'b0;
  logic        rst;
  logic        in_valid  [4];
  logic        in_ready  [4];
  logic [47:0] in_data   [4];
  logic        out_valid [4];
  logic        out_ready [4];
  logic [31:0] out_data  [4];
  logic        busy      [4];

  always #5 clk = ~clk;

  for (genvar g = 0; g < 4; g++) begin : g_dut
    des_sbox_engine #(.LANES(1 << g)) u_dut (
      .clk       (clk),
      .rst       (rst),
      .in_valid  (in_valid[g]),
      .in_ready  (in_ready[g]),
      .in_data   (in_data[g]),
      .out_valid (out_valid[g]),
      .out_ready (out_ready[g]),
      .out_data  (out_data[g]),
      .busy      (busy[g])
    );
  end

  int errors = 0;
  int checks = 0;
  logic [31:0] exp_q [$];

  typedef struct {
    int          l;
    logic [47:0] d;
    logic [31:0] e;
  } vec_t;
  vec_t tbl [8];

  task automatic check(input string nm, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  function automatic logic [31:0] model(input logic [47:0] d);
    logic [31:0] r;
    logic [5:0]  f;
    int          idx;
    r = '0;
    for (int k = 0; k < 8; k++) begin
      f   = d[47 - 6*k -: 6];
      idx = (f[5] ? 32 : 0) + (f[0] ? 16 : 0) + int'(f[4:1]);
      r[31 - 4*k -: 4] = SBOX[k][255 - 4*idx -: 4];
    end
    return r;
  endfunction

  // Counts edges after the accept edge until out_valid, scrambling in_data meanwhile.
  task automatic wait_out(input int l, output int cnt);
    cnt = 0;
    for (int i = 0; i < 20; i++) begin
      in_data[l] = {16'($urandom), $urandom};
      @(posedge clk);
      #1;
      cnt++;
      if (out_valid[l]) break;
    end
  endtask

  task automatic do_vec(input int l, input logic [47:0] d, input logic [31:0] e,
                        input string nm);
    int          cnt;
    logic [31:0] exp;
    @(posedge clk);
    #1;
    in_valid[l]  = 1'b1;
    in_data[l]   = d;
    out_ready[l] = 1'b1;
    @(negedge clk);
    check({nm, "_in_ready"}, 64'(in_ready[l]), 64'd1);
    @(posedge clk);
    exp_q.push_back(e);
    #1;
    in_valid[l] = 1'b0;
    wait_out(l, cnt);
    check({nm, "_latency"}, 64'(cnt), 64'(8 >> l));
    exp = exp_q.pop_front();
    check({nm, "_data"}, 64'(out_data[l]), 64'(exp));
  endtask

  initial begin
    int          cnt;
    logic [31:0] snap;
    logic [31:0] exp;
    logic [47:0] d;
    bit          ok;

    tbl[0] = '{1, 48'h000000000000, 32'hEFA72C4D};
    tbl[1] = '{3, 48'hFFFFFFFFFFFF, 32'hD9CE3DCB};
    tbl[2] = '{0, 48'h000000000000, 32'hEFA72C4D};
    tbl[3] = '{2, 48'hFFFFFFFFFFFF, 32'hD9CE3DCB};
    tbl[4] = '{0, 48'h041041041041, 32'h03DDEAD1};
    tbl[5] = '{3, 48'h041041041041, 32'h03DDEAD1};
    tbl[6] = '{1, 48'h820820820820, 32'h40DA4917};
    tbl[7] = '{2, 48'h820820820820, 32'h40DA4917};

    rst = 1'b1;
    for (int l = 0; l < 4; l++) begin
      in_valid[l]  = 1'b0;
      in_data[l]   = '0;
      out_ready[l] = 1'b0;
    end
    repeat (2) @(posedge clk);
    #1;
    rst = 1'b0;
    @(negedge clk);
    for (int l = 0; l < 4; l++) begin
      check($sformatf("reset_out_valid_%0d", l), 64'(out_valid[l]), 64'd0);
      check($sformatf("reset_out_data_%0d", l), 64'(out_data[l]), 64'd0);
      check($sformatf("reset_busy_%0d", l), 64'(busy[l]), 64'd0);
      check($sformatf("reset_in_ready_%0d", l), 64'(in_ready[l]), 64'd1);
    end

    for (int i = 0; i < 8; i++) begin
      do_vec(tbl[i].l, tbl[i].d, tbl[i].e, $sformatf("table%0d", i));
    end

    // Backpressure on LANES=1: result held for 5 cycles, delivered once.
    @(posedge clk);
    #1;
    in_valid[0]  = 1'b1;
    in_data[0]   = 48'h820820820820;
    out_ready[0] = 1'b0;
    @(posedge clk);
    exp_q.push_back(32'h40DA4917);
    #1;
    in_valid[0] = 1'b0;
    wait_out(0, cnt);
    check("bp_latency", 64'(cnt), 64'd8);
    snap = out_data[0];
    exp  = exp_q.pop_front();
    check("bp_data", 64'(snap), 64'(exp));
    for (int i = 0; i < 5; i++) begin
      @(posedge clk);
      #1;
      ok = out_valid[0] && (out_data[0] == snap) && !in_ready[0];
      check($sformatf("bp_hold_%0d", i), 64'(ok), 64'd1);
    end
    out_ready[0] = 1'b1;
    @(posedge clk);
    #1;
    check("bp_released_out_valid", 64'(out_valid[0]), 64'd0);
    check("bp_released_busy", 64'(busy[0]), 64'd0);

    // Back-to-back on LANES=2: new accept in DONE restarts RUN with no bubble.
    @(posedge clk);
    #1;
    in_valid[1]  = 1'b1;
    in_data[1]   = 48'h0;
    out_ready[1] = 1'b1;
    @(posedge clk);
    exp_q.push_back(32'hEFA72C4D);
    #1;
    in_valid[1] = 1'b0;
    wait_out(1, cnt);
    check("b2b_first_latency", 64'(cnt), 64'd4);
    exp = exp_q.pop_front();
    check("b2b_first_data", 64'(out_data[1]), 64'(exp));
    check("b2b_done_in_ready", 64'(in_ready[1]), 64'd1);
    in_valid[1] = 1'b1;
    in_data[1]  = 48'hFFFFFFFFFFFF;
    @(posedge clk);
    exp_q.push_back(32'hD9CE3DCB);
    #1;
    in_valid[1] = 1'b0;
    check("b2b_restart_out_valid", 64'(out_valid[1]), 64'd0);
    check("b2b_restart_busy", 64'(busy[1]), 64'd1);
    check("b2b_restart_in_ready", 64'(in_ready[1]), 64'd0);
    wait_out(1, cnt);
    check("b2b_second_latency", 64'(cnt), 64'd4);
    exp = exp_q.pop_front();
    check("b2b_second_data", 64'(out_data[1]), 64'(exp));

    // Reset in RUN step 1 on LANES=2 discards the operation.
    @(posedge clk);
    #1;
    in_valid[1] = 1'b1;
    in_data[1]  = 48'h0;
    @(posedge clk);
    #1;
    in_valid[1] = 1'b0;
    @(posedge clk);
    #1;
    rst = 1'b1;
    @(posedge clk);
    #1;
    rst = 1'b0;
    check("midrst_out_valid", 64'(out_valid[1]), 64'd0);
    check("midrst_out_data", 64'(out_data[1]), 64'd0);
    check("midrst_busy", 64'(busy[1]), 64'd0);
    check("midrst_in_ready", 64'(in_ready[1]), 64'd1);
    ok = 1'b1;
    for (int i = 0; i < 6; i++) begin
      @(posedge clk);
      #1;
      if (out_valid[1]) ok = 1'b0;
    end
    check("midrst_no_result", 64'(ok), 64'd1);
    do_vec(1, 48'h041041041041, 32'h03DDEAD1, "midrst_next");

    for (int l = 0; l < 4; l++) begin
      for (int i = 0; i < 1000; i++) begin
        d = {16'($urandom), $urandom};
        do_vec(l, d, model(d), $sformatf("rand_l%0d", l));
      end
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
